// File: rtl/mux_n1_scan_reg_pkg.sv
// Shared FSM encodings and the clog2 helper for the registered N:1 scan mux.
package mux_n1_scan_reg_pkg;

  typedef enum logic {
    ST_MAN  = 1'b0,
    ST_SCAN = 1'b1
  } st_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < n) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/mux_n1_scan_reg_if.sv
// Channel bus of the scan mux; optional scan_hold exists only with MUX_SCAN_HOLD_EN.
interface mux_n1_scan_reg_if #(
  parameter int N  = 8,
  parameter int W  = 1,
  parameter int DW = 8
);
  localparam int SW = mux_n1_scan_reg_pkg::clog2(N);

  logic          en_n;
  logic          mode;
  logic [SW-1:0] sel;
  logic [DW-1:0] dwell;
  logic [N*W-1:0] din;
  logic [W-1:0]  dout;
  logic [SW-1:0] ch;
  logic          valid;
  logic          wrap;
`ifdef MUX_SCAN_HOLD_EN
  logic          scan_hold;
`endif

  modport master (
`ifdef MUX_SCAN_HOLD_EN
    output scan_hold,
`endif
    output en_n, mode, sel, dwell, din,
    input  dout, ch, valid, wrap
  );

  modport slave (
`ifdef MUX_SCAN_HOLD_EN
    input  scan_hold,
`endif
    input  en_n, mode, sel, dwell, din,
    output dout, ch, valid, wrap
  );

endinterface

// File: rtl/mux_n1_scan_reg_scan_ctr.sv
// Dwell counter and channel-advance/wrap logic for the auto-scan sequencer.
module mux_n1_scan_reg_scan_ctr #(
  parameter int N  = 8,
  parameter int SW = 3,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          hold,
  input  logic [DW-1:0] dwell,
  input  logic [SW-1:0] ch,
  output logic [SW-1:0] ch_scan,
  output logic          wrap_scan
);
  localparam logic [SW:0]   NL   = (SW+1)'(N);
  localparam logic [SW-1:0] LAST = SW'(N - 1);

  logic [DW-1:0] cnt;
  logic          bad_ch;
  logic          adv;

  assign bad_ch = ({1'b0, ch} >= NL);
  // >= rather than == so a dwell lowered under the running count advances at once
  assign adv    = (cnt >= dwell);

  always_comb begin
    ch_scan   = ch;
    wrap_scan = 1'b0;
    if (!hold) begin
      if (bad_ch) begin
        ch_scan = '0;
      end else if (adv) begin
        ch_scan   = (ch == LAST) ? '0 : ch + SW'(1);
        wrap_scan = (ch == LAST);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr)       cnt <= '0;
    else if (hold)        cnt <= cnt;
    else if (bad_ch || adv) cnt <= '0;
    else                  cnt <= cnt + DW'(1);
  end

endmodule

// File: rtl/mux_n1_scan_reg.sv
// Registered N:1 mux with active-low enable and auto-scan mode.
// Build option: define MUX_SCAN_HOLD_EN to add the scan_hold freeze input.
module mux_n1_scan_reg
  import mux_n1_scan_reg_pkg::*;
#(
  parameter int N  = 8,
  parameter int W  = 1,
  parameter int DW = 8
) (
  input logic            clk,
  input logic            rst,
  mux_n1_scan_reg_if.slave bus
);
  localparam int          SW = clog2(N);
  localparam logic [SW:0] NL = (SW+1)'(N);

  st_e           st, st_nxt;
  logic [SW-1:0] ch_q, ch_nxt, ch_scan;
  logic [W-1:0]  dout_q, dout_nxt;
  logic          valid_q, wrap_q, wrap_scan, hold, scanning;

`ifdef MUX_SCAN_HOLD_EN
  assign hold = bus.scan_hold;
`else
  assign hold = 1'b0;
`endif

  // en_n freezes the state; otherwise the state simply follows mode
  assign st_nxt   = bus.en_n ? st : st_e'(bus.mode);
  assign scanning = !bus.en_n && (st_nxt == ST_SCAN);
  assign ch_nxt   = (st_nxt == ST_SCAN) ? ch_scan : bus.sel;

  mux_n1_scan_reg_scan_ctr #(.N(N), .SW(SW), .DW(DW)) u_ctr (
    .clk      (clk),
    .rst      (rst),
    .clr      (!scanning),
    .hold     (hold),
    .dwell    (bus.dwell),
    .ch       (ch_q),
    .ch_scan  (ch_scan),
    .wrap_scan(wrap_scan)
  );

  // Out-of-range indices match no channel, so dout_nxt masks to zero
  always_comb begin
    dout_nxt = '0;
    for (int k = 0; k < N; k++)
      if (ch_nxt == SW'(k)) dout_nxt = bus.din[k*W +: W];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st      <= ST_MAN;
      ch_q    <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
    end else if (bus.en_n) begin
      dout_q  <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      st      <= st_nxt;
      ch_q    <= ch_nxt;
      dout_q  <= dout_nxt;
      valid_q <= ({1'b0, ch_nxt} < NL);
      wrap_q  <= scanning && wrap_scan;
    end
  end

  assign bus.dout  = dout_q;
  assign bus.ch    = ch_q;
  assign bus.valid = valid_q;
  assign bus.wrap  = wrap_q;

endmodule

// File: tb/tb_mux_n1_scan_reg.sv
// Directed bench for mux_n1_scan_reg: an N=8 and an N=6 instance, W=4, din[k]=k+1.
module tb_mux_n1_scan_reg;

  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  mux_n1_scan_reg_if #(.N(8), .W(4), .DW(8)) b8();
  mux_n1_scan_reg_if #(.N(6), .W(4), .DW(8)) b6();

  mux_n1_scan_reg #(.N(8), .W(4), .DW(8)) u8 (.clk(clk), .rst(rst), .bus(b8.slave));
  mux_n1_scan_reg #(.N(6), .W(4), .DW(8)) u6 (.clk(clk), .rst(rst), .bus(b6.slave));

  typedef struct {
    logic       en_n;
    logic       mode;
    logic [2:0] sel;
    logic [3:0] e_dout;
    logic [2:0] e_ch;
    logic       e_valid;
    logic       e_wrap;
  } vec_t;

  vec_t vt[$];

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk8(input string nm, input int ed, input int ec, input int ev, input int ew);
    chk({nm, " dout"},  int'(b8.dout),  ed);
    chk({nm, " ch"},    int'(b8.ch),    ec);
    chk({nm, " valid"}, int'(b8.valid), ev);
    chk({nm, " wrap"},  int'(b8.wrap),  ew);
  endtask

  task automatic chk6(input string nm, input int ed, input int ec, input int ev, input int ew);
    chk({nm, " dout"},  int'(b6.dout),  ed);
    chk({nm, " ch"},    int'(b6.ch),    ec);
    chk({nm, " valid"}, int'(b6.valid), ev);
    chk({nm, " wrap"},  int'(b6.wrap),  ew);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int e;
    // Manual-mode and enable vectors: sel stepped every 2 cycles, then en_n blocking
    for (int s = 0; s < 8; s++)
      for (int r = 0; r < 2; r++)
        vt.push_back('{1'b0, 1'b0, 3'(s), 4'(s + 1), 3'(s), 1'b1, 1'b0});
    vt.push_back('{1'b1, 1'b0, 3'd3, 4'd0, 3'd7, 1'b0, 1'b0});
    vt.push_back('{1'b1, 1'b0, 3'd3, 4'd0, 3'd7, 1'b0, 1'b0});
    vt.push_back('{1'b0, 1'b0, 3'd3, 4'd4, 3'd3, 1'b1, 1'b0});

    for (int k = 0; k < 8; k++) b8.din[k*4 +: 4] = 4'(k + 1);
    for (int k = 0; k < 6; k++) b6.din[k*4 +: 4] = 4'(k + 1);
    b8.en_n = 1'b1; b8.mode = 1'b0; b8.sel = '0; b8.dwell = '0;
    b6.en_n = 1'b1; b6.mode = 1'b0; b6.sel = '0; b6.dwell = '0;
`ifdef MUX_SCAN_HOLD_EN
    b8.scan_hold = 1'b0;
    b6.scan_hold = 1'b0;
`endif

    rst = 1'b1;
    tick();
    chk8("reset", 0, 0, 0, 0);
    rst = 1'b0;

    // T2/T3 table
    for (int i = 0; i < vt.size(); i++) begin
      b8.en_n = vt[i].en_n; b8.mode = vt[i].mode; b8.sel = vt[i].sel;
      tick();
      chk8($sformatf("vec%0d", i), int'(vt[i].e_dout), int'(vt[i].e_ch),
           int'(vt[i].e_valid), int'(vt[i].e_wrap));
    end

    // T4: scan with dwell=2 from ch 0; channel k>0 shows on edges 3k..3k+2
    b8.mode = 1'b0; b8.sel = 3'd0;
    tick();
    chk8("t4 start", 1, 0, 1, 0);
    b8.mode = 1'b1; b8.dwell = 8'd2;
    for (int j = 1; j <= 26; j++) begin
      tick();
      e = (j / 3) % 8;
      chk8($sformatf("t4 j%0d", j), e + 1, e, 1, (j == 24) ? 1 : 0);
    end

    // T1: reset mid-scan at ch 5, scan restarts from 0
    b8.mode = 1'b0; b8.sel = 3'd5;
    tick();
    b8.mode = 1'b1;
    tick();
    chk8("t1 pre", 6, 5, 1, 0);
    rst = 1'b1;
    tick();
    chk8("t1 rst", 0, 0, 0, 0);
    rst = 1'b0;
    tick();
    chk8("t1 resume", 1, 0, 1, 0);

    // T5: dwell=0 from ch 2, wrap on 7->0
    b8.mode = 1'b0; b8.sel = 3'd2;
    tick();
    b8.mode = 1'b1; b8.dwell = 8'd0;
    for (int j = 1; j <= 6; j++) begin
      tick();
      e = (2 + j) % 8;
      chk8($sformatf("t5 d0 j%0d", j), e + 1, e, 1, (e == 0) ? 1 : 0);
    end
    // dwell cut from 5 to 1 once the count has reached 3
    b8.mode = 1'b0; b8.sel = 3'd1;
    tick();
    b8.mode = 1'b1; b8.dwell = 8'd5;
    for (int j = 1; j <= 3; j++) begin
      tick();
      chk8($sformatf("t5 d5 j%0d", j), 2, 1, 1, 0);
    end
    b8.dwell = 8'd1;
    tick();
    chk8("t5 cut", 3, 2, 1, 0);
    tick();
    chk8("t5 d1 hold", 3, 2, 1, 0);
    tick();
    chk8("t5 d1 adv", 4, 3, 1, 0);
    b8.en_n = 1'b1;
    tick();
    chk8("scan blocked", 0, 3, 0, 0);
    b8.en_n = 1'b0;
    tick();
    chk8("scan reenable", 4, 3, 1, 0);
    tick();
    chk8("scan reenable adv", 5, 4, 1, 0);
    b8.mode = 1'b0; b8.sel = 3'd6;
    tick();
    chk8("scan to man", 7, 6, 1, 0);

    // T6: N=6 illegal sel, scan entry, 5->0 wrap
    b6.en_n = 1'b0; b6.mode = 1'b0; b6.sel = 3'd7;
    tick();
    chk6("t6 sel7", 0, 7, 0, 0);
    b6.mode = 1'b1; b6.dwell = 8'd2;
    tick();
    chk6("t6 entry", 1, 0, 1, 0);
    b6.mode = 1'b0; b6.sel = 3'd4;
    tick();
    chk6("t6 man4", 5, 4, 1, 0);
    b6.mode = 1'b1; b6.dwell = 8'd0;
    tick();
    chk6("t6 ch5", 6, 5, 1, 0);
    tick();
    chk6("t6 wrap", 1, 0, 1, 1);
    tick();
    chk6("t6 after wrap", 2, 1, 1, 0);
`ifdef MUX_SCAN_HOLD_EN
    b6.mode = 1'b0; b6.sel = 3'd5;
    tick();
    b6.mode = 1'b1; b6.scan_hold = 1'b1;
    for (int j = 1; j <= 10; j++) begin
      tick();
      chk6($sformatf("hold j%0d", j), 6, 5, 1, 0);
    end
    b6.scan_hold = 1'b0;
    tick();
    chk6("hold release", 1, 0, 1, 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
